// File: rtl/fbound_pkg.sv
// Shared types and constants for the float-bound clip arbiter.
// SP-FP field widths, requester count and the controller state encoding.
package fbound_pkg;

    localparam int NREQ   = 4;
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

    typedef enum logic [2:0] {
        IDLE,
        CFG_LO,
        CFG_HI,
        RUN,
        WAIT
    } state_t;

endpackage

// File: rtl/fbound_rr_arb.sv
// Combinational 4-way round-robin pick.
// Search starts at the requester after ptr and wraps back to ptr last.
module fbound_rr_arb
    import fbound_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            gnt_valid,
    output logic [1:0]      gnt_idx
);

    logic [1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr + 2'(k);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fbound_arb.sv
// Arbitrates 4 requesters onto one external SP-FP bound clipper.
// Define FBOUND_ARB_STATS_EN to add the clip_cnt statistics output.
module fbound_arb
    import fbound_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [FP_W-1:0]   cfg_low,
    input  logic [FP_W-1:0]   cfg_high,
    output logic              cfg_done,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [FP_W-1:0]   res_data,
    output logic              res_in_bounds,
    output logic              busy,
    output logic [FP_W-1:0]   cl_din,
    output logic              cl_init,
    output logic              cl_start,
    input  logic [FP_W-1:0]   cl_dout,
    input  logic              cl_in_bounds,
    input  logic              cl_finished
`ifdef FBOUND_ARB_STATS_EN
    ,
    output logic [15:0]       clip_cnt
`endif
);

    state_t     state;
    logic       bnd_valid;
    logic [1:0] ptr;
    logic [1:0] win;
    logic       gnt_valid;
    logic [1:0] gnt_idx;

    fbound_rr_arb u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bnd_valid     <= 1'b0;
            ptr           <= 2'd3;
            win           <= 2'd0;
            cl_din        <= '0;
            cl_init       <= 1'b0;
            cl_start      <= 1'b0;
            ack           <= '0;
            res_data      <= '0;
            res_in_bounds <= 1'b0;
            cfg_done      <= 1'b0;
            busy          <= 1'b0;
`ifdef FBOUND_ARB_STATS_EN
            clip_cnt      <= '0;
`endif
        end else begin
            cl_init  <= 1'b0;
            cl_start <= 1'b0;
            ack      <= '0;
            cfg_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        cl_din  <= cfg_low;
                        cl_init <= 1'b1;
                        state   <= CFG_LO;
                        busy    <= 1'b1;
                    end else if (bnd_valid && gnt_valid) begin
                        win      <= gnt_idx;
                        ptr      <= gnt_idx;
                        cl_din   <= req_data[{gnt_idx, 5'd0} +: FP_W];
                        cl_start <= 1'b1;
                        state    <= RUN;
                        busy     <= 1'b1;
                    end
                end
                CFG_LO: begin
                    cl_din <= cfg_high;
                    state  <= CFG_HI;
                end
                CFG_HI: begin
                    cfg_done  <= 1'b1;
                    bnd_valid <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
`ifdef FBOUND_ARB_STATS_EN
                    clip_cnt  <= '0;
`endif
                end
                RUN: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // cl_din stays put: the clipper re-reads it when it finishes
                    if (cl_finished) begin
                        res_data      <= cl_dout;
                        res_in_bounds <= cl_in_bounds;
                        ack   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef FBOUND_ARB_STATS_EN
                        if (!cl_in_bounds && clip_cnt != 16'hFFFF)
                            clip_cnt <= clip_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fbound_arb.sv
// Directed bench for fbound_arb with a behavioural bound clipper.
module tb_fbound_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic [31:0]  cfg_low, cfg_high;
    logic         cfg_done;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic [31:0]  res_data;
    logic         res_in_bounds, busy;
    logic [31:0]  cl_din, cl_dout;
    logic         cl_init, cl_start, cl_in_bounds, cl_finished;

    int n_checks = 0;
    int n_fail   = 0;
    logic both_seen = 1'b0;

    always #5 clk = ~clk;

    fbound_arb dut (
        .clk           (clk),
        .reset         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_low       (cfg_low),
        .cfg_high      (cfg_high),
        .cfg_done      (cfg_done),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .res_data      (res_data),
        .res_in_bounds (res_in_bounds),
        .busy          (busy),
        .cl_din        (cl_din),
        .cl_init       (cl_init),
        .cl_start      (cl_start),
        .cl_dout       (cl_dout),
        .cl_in_bounds  (cl_in_bounds),
        .cl_finished   (cl_finished)
    );

    // Ordering key: maps SP-FP bit patterns to unsigned order
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
        return fkey(a) < fkey(b);
    endfunction

    // Clipper: finishes 1 edge after start when below low, else 2
    logic [31:0] m_lo, m_hi;
    logic        m_ph;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lo <= '0; m_hi <= '0; m_ph <= 1'b0; m_cnt <= 0;
            cl_finished <= 1'b0; cl_dout <= '0; cl_in_bounds <= 1'b0;
        end else begin
            if (cl_init) begin
                m_lo <= cl_din;
                m_ph <= 1'b1;
            end else if (m_ph) begin
                m_hi <= cl_din;
                m_ph <= 1'b0;
            end
            if (cl_start) begin
                cl_finished <= 1'b0;
                m_cnt <= flt(cl_din, m_lo) ? 1 : 2;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    cl_finished <= 1'b1;
                    if (flt(cl_din, m_lo)) begin
                        cl_dout <= m_lo; cl_in_bounds <= 1'b0;
                    end else if (flt(m_hi, cl_din)) begin
                        cl_dout <= m_hi; cl_in_bounds <= 1'b0;
                    end else begin
                        cl_dout <= cl_din; cl_in_bounds <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk)
        if (cl_init && cl_start) both_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int bound, output int cyc,
                            output logic [3:0] a);
        cyc = 0;
        a = '0;
        for (int i = 0; i < bound && a == 4'd0; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            a = ack;
        end
    endtask

    task automatic wait_cfg(output int cyc, output logic done,
                            output logic saw_ack);
        cyc = 0;
        done = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = cfg_done;
            if (ack != 4'd0) saw_ack = 1'b1;
        end
    endtask

    task automatic do_cfg(input string tag, input logic [31:0] lo,
                          input logic [31:0] hi);
        int cyc; logic done, sa;
        cfg_valid = 1'b1; cfg_low = lo; cfg_high = hi;
        wait_cfg(cyc, done, sa);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, cyc, 32'd3);
        chk({tag, "_noack"}, 32'(sa), 32'd0);
        cfg_valid = 1'b0;
    endtask

    task automatic do_req(input string tag, input int idx,
                          input logic [31:0] d, input logic [31:0] er,
                          input logic ei, input int elat);
        int cyc; logic [3:0] a;
        req[idx] = 1'b1;
        req_data[idx*32 +: 32] = d;
        wait_ack(20, cyc, a);
        chk({tag, "_ack"}, 32'(a), 32'(4'b1 << idx));
        chk({tag, "_res"}, res_data, er);
        chk({tag, "_inb"}, 32'(res_in_bounds), 32'(ei));
        chk({tag, "_lat"}, cyc, elat);
        req[idx] = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_din"}, cl_din, 32'd0);
        chk({tag, "_ctl"}, {29'd0, cl_init, cl_start, cfg_done}, 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_res"}, res_data, 32'd0);
        chk({tag, "_inb"}, 32'(res_in_bounds), 32'd0);
    endtask

    initial begin
        int cyc; logic [3:0] a; logic done, sa;
        logic [3:0]  ord [5];
        logic [31:0] ores [4];
        ord  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ores = '{32'h3F00_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3E80_0000};
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_low = '0; cfg_high = '0;
        req = '0; req_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        // no bounds loaded yet: requests are ignored
        req[0] = 1'b1; req_data[31:0] = 32'h3F00_0000;
        wait_ack(6, cyc, a);
        chk("nobnd_ack", 32'(a), 32'd0);
        chk("nobnd_busy", 32'(busy), 32'd0);

        do_cfg("cfg1", 32'hBF80_0000, 32'h3F80_0000);
        req[0] = 1'b0;

        do_req("in0", 0, 32'h3F00_0000, 32'h3F00_0000, 1'b1, 5);
        do_req("lo1", 1, 32'hC000_0000, 32'hBF80_0000, 1'b0, 4);
        do_req("hi2", 2, 32'h4000_0000, 32'h3F80_0000, 1'b0, 5);

        // reset while waiting on the clipper
        req[3] = 1'b1; req_data[127:96] = 32'h3F00_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(8, cyc, a);
        chk("postrst_ack", 32'(a), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        req[3] = 1'b0;

        do_cfg("cfg2", 32'hBF80_0000, 32'h3F80_0000);

        // all four held: strict rotation from requester 0
        req_data = {32'h3E80_0000, 32'h4000_0000, 32'hC000_0000, 32'h3F00_0000};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(20, cyc, a);
            chk($sformatf("rr%0d_ack", i), 32'(a), 32'(ord[i]));
            chk($sformatf("rr%0d_res", i), res_data, ores[i % 4]);
        end
        req = 4'b0000;

        // reload requested while a sample is in flight
        req[1] = 1'b1; req_data[63:32] = 32'h3FC0_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_low = 32'hC000_0000; cfg_high = 32'h4000_0000;
        wait_ack(20, cyc, a);
        chk("old_ack", 32'(a), 32'b0010);
        chk("old_res", res_data, 32'h3F80_0000);
        chk("old_inb", 32'(res_in_bounds), 32'd0);
        req[1] = 1'b0;
        wait_cfg(cyc, done, sa);
        chk("reload_done", 32'(done), 32'd1);
        cfg_valid = 1'b0;
        do_req("new1", 1, 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 5);
        do_req("new2", 2, 32'hC040_0000, 32'hC000_0000, 1'b0, 4);

        chk("init_start_excl", 32'(both_seen), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fbound_arb.md
FBOUND_ARB -- requirements
Module: fbound_arb

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cfg_valid  in  1  bound-load request; cfg_low, cfg_high held until cfg_done.
REQ-004 SHALL have ports: cfg_low  in  32  SP-FP low bound.
REQ-005 SHALL have ports: cfg_high  in  32  SP-FP high bound.
REQ-006 SHALL have ports: cfg_done  out  1  one-cycle pulse when both bounds are loaded.
REQ-007 SHALL have ports: req  in  4  per-requester clip request; req[i] and its data held until ack[i].
REQ-008 SHALL have ports: req_data  in  128  requester i sample at bits [32i+31:32i].
REQ-009 SHALL have ports: ack  out  4  one-hot one-cycle result pulse.
REQ-010 SHALL have ports: res_data  out  32  clipped result, valid with ack.
REQ-011 SHALL have ports: res_in_bounds  out  1  sample was within bounds, valid with ack.
REQ-012 SHALL have ports: busy  out  1  state not IDLE.
REQ-013 SHALL have ports: cl_din  out  32  clipper data.
REQ-014 SHALL have ports: cl_init  out  1  clipper init.
REQ-015 SHALL have ports: cl_start  out  1  clipper start.
REQ-016 SHALL have ports: cl_dout  in  32  clipper result.
REQ-017 SHALL have ports: cl_in_bounds  in  1  clipper in-bounds flag.
REQ-018 SHALL have ports: cl_finished  in  1  clipper done flag.
REQ-019 SHALL have parameter: NREQ, default 4, number of requesters (fixed at 4 in this release).

Function
REQ-020 SHALL register all outputs and never assert cl_init and cl_start in the same cycle.
REQ-021 SHALL have states IDLE, CFG_LO, CFG_HI, RUN, WAIT.
REQ-022 In IDLE, cfg_valid SHALL have priority over req: register cl_din=cfg_low, cl_init=1, then go to CFG_LO.
REQ-023 In CFG_LO, SHALL register cl_init=0, cl_din=cfg_high, then go to CFG_HI.
REQ-024 In CFG_HI, SHALL pulse cfg_done, set bnd_valid=1, then go to IDLE (3 cycles total from the IDLE decision).
REQ-025 While bnd_valid=0, SHALL ignore req.
REQ-026 In IDLE, with bnd_valid=1 and no cfg_valid, SHALL choose the round-robin winner starting after the last granted index.
REQ-027 On a grant, SHALL latch the winner index, register cl_din=sample and cl_start=1, then go to RUN.
REQ-028 In RUN, SHALL register cl_start=0, hold cl_din, then go to WAIT.
REQ-029 SHALL hold cl_din stable through WAIT, because the clipper re-samples din in its final cycle.
REQ-030 In WAIT, on cl_finished=1, SHALL register res_data=cl_dout, res_in_bounds=cl_in_bounds, ack[winner]=1, then go to IDLE.
REQ-031 Grant-to-ack latency SHALL be 4 cycles for a sample below low, and 5 cycles otherwise.
REQ-032 SHALL not wait for cl_finished=0; the clipper deasserts it on the edge that ends RUN.
REQ-033 cfg_valid arriving during RUN or WAIT SHALL wait for IDLE; the in-flight sample completes with the old bounds.
REQ-034 SHALL drop a req deasserted before ack without error; the arbiter SHALL not re-sample req_data after the grant.

Reset
REQ-035 On reset low, asynchronously: state=IDLE; bnd_valid=0; rr pointer=3 (requester 0 first); cl_din=0; cl_init=0; cl_start=0; ack=0; res_data=0; res_in_bounds=0; cfg_done=0; busy=0.
REQ-036 The clipper SHALL share the same reset, so reset mid-operation returns both blocks to idle and requires a new bound load.

Configuration
REQ-037 Macro FBOUND_ARB_STATS_EN defined: SHALL add output clip_cnt (16 bits), which increments on each ack with res_in_bounds=0, saturates at 0xFFFF, resets to 0, and clears on cfg_done.
REQ-038 Macro FBOUND_ARB_STATS_EN undefined: SHALL omit the clip_cnt port and its counter.

Structure
REQ-039 Package fbound_pkg SHALL hold the state encoding, NREQ, and SP-FP field widths (sign 1, exp 8, man 23).
REQ-040 Sub-module fbound_rr_arb SHALL implement the combinational 4-way round-robin pick from req and the pointer.
REQ-041 The clipper SHALL be instantiated outside this block.

Verification
REQ-042 Config cfg_low=0xBF800000 (-1.0) and cfg_high=0x3F800000 (1.0) -> cfg_done 3 cycles after the IDLE decision; no ack before it, even with req pending.
REQ-043 req[0] with 0x3F000000 (0.5) -> ack[0] 5 cycles after grant, res_data=0x3F000000, res_in_bounds=1.
REQ-044 req[1] with 0xC0000000 (-2.0) -> ack[1] 4 cycles after grant, res_data=0xBF800000, res_in_bounds=0; req[2] with 0x40000000 (2.0) -> res_data=0x3F800000, res_in_bounds=0.
REQ-045 req=4'b1111 held -> ack order 0,1,2,3,0; no requester is served twice before all others are served.
REQ-046 cfg_valid raised during WAIT -> current ack uses the old bounds, then the reload, then the next grant uses the new bounds.
REQ-047 Reset pulsed in WAIT -> all outputs take reset values, and the next req is ignored until a new config completes.
